mips_rf_access_ctrl: RTL and testbench

//  Initiator side of the MIPS register file port set. Drives RA1/RA2/WA/WD/wen
//  of a MIPS_Register_File and returns operand pairs to the pipeline over a

---
 rtl/mips_rf_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_mips_rf_access_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_rf_access_ctrl.sv
// rtl/mips_rf_access_ctrl.sv - operand read/writeback controller for a MIPS register file
// Optional RF_ACC_STATS_EN adds the fwd_cnt forwarded-accept counter port.
module mips_rf_access_ctrl #(
    parameter int AWL  = 5,
    parameter int DWL  = 32,
    parameter int MODE = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [AWL-1:0] req_ra1,
    input  logic [AWL-1:0] req_ra2,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [DWL-1:0] rsp_rd1,
    output logic [DWL-1:0] rsp_rd2,
    input  logic           wb_valid,
    input  logic [AWL-1:0] wb_wa,
    input  logic [DWL-1:0] wb_wd,
    output logic           rf_wen,
    output logic [AWL-1:0] rf_wa,
    output logic [DWL-1:0] rf_wd,
    output logic [AWL-1:0] rf_ra1,
    output logic [AWL-1:0] rf_ra2,
    input  logic [DWL-1:0] rf_rd1,
    input  logic [DWL-1:0] rf_rd2
`ifdef RF_ACC_STATS_EN
    ,
    output logic [15:0]    fwd_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic SYNC_RD = (MODE != 0);

    state_t         state, state_nxt;
    logic           accept;
    logic           load_now, load_wait;
    logic           fwd1, fwd2;
    logic [AWL-1:0] ra1_q, ra2_q;
    logic           fwd1_q, fwd2_q;
    logic           zero1_q, zero2_q;
    logic [DWL-1:0] fwd_d1_q, fwd_d2_q;
    logic [DWL-1:0] op1_now, op2_now;
    logic [DWL-1:0] op1_wait, op2_wait;

    assign req_ready = !rst && ((state == IDLE) || ((state == RESP) && rsp_ready));
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);

    // $zero is architecturally read-only, so writes to it never reach the file
    assign rf_wen = !rst && wb_valid && (wb_wa != '0);
    assign rf_wa  = wb_wa;
    assign rf_wd  = wb_wd;

    assign rf_ra1 = accept ? req_ra1 : ra1_q;
    assign rf_ra2 = accept ? req_ra2 : ra2_q;

    assign fwd1 = wb_valid && (wb_wa == req_ra1) && (req_ra1 != '0);
    assign fwd2 = wb_valid && (wb_wa == req_ra2) && (req_ra2 != '0);

    assign op1_now = (req_ra1 == '0) ? '0 : (fwd1 ? wb_wd : rf_rd1);
    assign op2_now = (req_ra2 == '0) ? '0 : (fwd2 ? wb_wd : rf_rd2);

    // Synchronous-read files deliver data one cycle late; the write seen in
    // the accept cycle may be missing from it, hence the latched forward
    assign op1_wait = zero1_q ? '0 : (fwd1_q ? fwd_d1_q : rf_rd1);
    assign op2_wait = zero2_q ? '0 : (fwd2_q ? fwd_d2_q : rf_rd2);

    always_comb begin
        state_nxt = state;
        load_now  = 1'b0;
        load_wait = 1'b0;
        case (state)
            IDLE: ;
            WAIT: begin
                load_wait = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (accept) begin
            state_nxt = SYNC_RD ? WAIT : RESP;
            load_now  = !SYNC_RD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra1_q    <= '0;
            ra2_q    <= '0;
            fwd1_q   <= 1'b0;
            fwd2_q   <= 1'b0;
            zero1_q  <= 1'b0;
            zero2_q  <= 1'b0;
            fwd_d1_q <= '0;
            fwd_d2_q <= '0;
        end else if (accept) begin
            ra1_q    <= req_ra1;
            ra2_q    <= req_ra2;
            fwd1_q   <= fwd1;
            fwd2_q   <= fwd2;
            zero1_q  <= (req_ra1 == '0);
            zero2_q  <= (req_ra2 == '0);
            fwd_d1_q <= wb_wd;
            fwd_d2_q <= wb_wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rd1 <= '0;
            rsp_rd2 <= '0;
        end else if (load_now) begin
            rsp_rd1 <= op1_now;
            rsp_rd2 <= op2_now;
        end else if (load_wait) begin
            rsp_rd1 <= op1_wait;
            rsp_rd2 <= op2_wait;
        end
    end

`ifdef RF_ACC_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_cnt <= '0;
        end else if (accept && (fwd1 || fwd2) && (fwd_cnt != 16'hFFFF)) begin
            fwd_cnt <= fwd_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_rf_access_ctrl.sv
// tb/tb_mips_rf_access_ctrl.sv - directed self-checking bench, one DUT per MODE
module tb_mips_rf_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rst       [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic [4:0]  req_ra1   [3];
    logic [4:0]  req_ra2   [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rd1   [3];
    logic [31:0] rsp_rd2   [3];
    logic        wb_valid  [3];
    logic [4:0]  wb_wa     [3];
    logic [31:0] wb_wd     [3];
    logic        rf_wen    [3];
    logic [4:0]  rf_wa     [3];
    logic [31:0] rf_wd     [3];
    logic [4:0]  rf_ra1    [3];
    logic [4:0]  rf_ra2    [3];
`ifdef RF_ACC_STATS_EN
    logic [15:0] fwd_cnt   [3];
`endif

    for (genvar g = 0; g < 3; g++) begin : g_m
        logic [31:0] mem [32] = '{default: 32'h0};
        logic [31:0] rd1, rd2;

        always @(posedge clk) if (rf_wen[g]) mem[rf_wa[g]] <= rf_wd[g];

        // Address 0 returns junk so the controller's own $zero handling is visible
        if (g == 0) begin : g_async
            assign rd1 = (rf_ra1[g] == 5'd0) ? 32'hDEAD0000 : mem[rf_ra1[g]];
            assign rd2 = (rf_ra2[g] == 5'd0) ? 32'hDEAD0000 : mem[rf_ra2[g]];
        end else begin : g_sync
            always @(posedge clk) begin
                rd1 <= (rf_ra1[g] == 5'd0) ? 32'hDEAD0000 :
                       ((g == 1) && rf_wen[g] && (rf_wa[g] == rf_ra1[g])) ? rf_wd[g] : mem[rf_ra1[g]];
                rd2 <= (rf_ra2[g] == 5'd0) ? 32'hDEAD0000 :
                       ((g == 1) && rf_wen[g] && (rf_wa[g] == rf_ra2[g])) ? rf_wd[g] : mem[rf_ra2[g]];
            end
        end

        mips_rf_access_ctrl #(.AWL(5), .DWL(32), .MODE(g)) dut (
            .clk       (clk),
            .rst       (rst[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_ra1   (req_ra1[g]),
            .req_ra2   (req_ra2[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rd1   (rsp_rd1[g]),
            .rsp_rd2   (rsp_rd2[g]),
            .wb_valid  (wb_valid[g]),
            .wb_wa     (wb_wa[g]),
            .wb_wd     (wb_wd[g]),
            .rf_wen    (rf_wen[g]),
            .rf_wa     (rf_wa[g]),
            .rf_wd     (rf_wd[g]),
            .rf_ra1    (rf_ra1[g]),
            .rf_ra2    (rf_ra2[g]),
            .rf_rd1    (rd1),
            .rf_rd2    (rd2)
`ifdef RF_ACC_STATS_EN
            ,
            .fwd_cnt   (fwd_cnt[g])
`endif
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int m, input logic v, input logic [4:0] a1, input logic [4:0] a2);
        req_valid[m] = v;
        req_ra1[m]   = a1;
        req_ra2[m]   = a2;
    endtask

    task automatic wb(input int m, input logic v, input logic [4:0] a, input logic [31:0] d);
        wb_valid[m] = v;
        wb_wa[m]    = a;
        wb_wd[m]    = d;
    endtask

    initial begin
        for (int m = 0; m < 3; m++) begin
            rst[m]       = 1'b1;
            rsp_ready[m] = 1'b1;
            req(m, 1'b0, 5'd0, 5'd0);
            wb(m, 1'b0, 5'd0, 32'h0);
        end
        wb(0, 1'b1, 5'd5, 32'h1111);
        req(1, 1'b1, 5'd1, 5'd2);
        #2;
        for (int m = 0; m < 3; m++) begin
            chk("rst_req_ready", req_ready[m], 1'b0);
            chk("rst_rsp_valid", rsp_valid[m], 1'b0);
            chk("rst_rd1", rsp_rd1[m], 32'h0);
            chk("rst_rd2", rsp_rd2[m], 32'h0);
        end
        chk("rst_wen", rf_wen[0], 1'b0);
        tick;
        tick;
        for (int m = 0; m < 3; m++) rst[m] = 1'b0;
        wb(0, 1'b0, 5'd0, 32'h0);
        req(1, 1'b0, 5'd0, 5'd0);

        // 1: MODE 0 read after write, operand 2 is $zero
        tick; wb(0, 1'b1, 5'd5, 32'h1234); #1;
        chk("t1_wen", rf_wen[0], 1'b1);
        tick; wb(0, 1'b0, 5'd0, 32'h0);
        tick; req(0, 1'b1, 5'd5, 5'd0); #1;
        chk("t1_req_ready", req_ready[0], 1'b1);
        chk("t1_rf_ra1", rf_ra1[0], 5'd5);
        tick; req(0, 1'b0, 5'd0, 5'd0);
        chk("t1_rsp_valid", rsp_valid[0], 1'b1);
        chk("t1_rd1", rsp_rd1[0], 32'h1234);
        chk("t1_rd2", rsp_rd2[0], 32'h0);
        tick;
        chk("t1_idle", rsp_valid[0], 1'b0);

        // 2: MODE 2 forwarding of an accept-cycle write
        tick; wb(2, 1'b1, 5'd7, 32'hAAAA);
        tick; wb(2, 1'b0, 5'd0, 32'h0);
        tick; req(2, 1'b1, 5'd7, 5'd7); wb(2, 1'b1, 5'd7, 32'hBBBB);
        tick; req(2, 1'b0, 5'd0, 5'd0); wb(2, 1'b0, 5'd0, 32'h0); #1;
        chk("t2_wait_valid", rsp_valid[2], 1'b0);
        chk("t2_wait_ready", req_ready[2], 1'b0);
        tick;
        chk("t2_rsp_valid", rsp_valid[2], 1'b1);
        chk("t2_rd1", rsp_rd1[2], 32'hBBBB);
        chk("t2_rd2", rsp_rd2[2], 32'hBBBB);
`ifdef RF_ACC_STATS_EN
        chk("t2_fwd_cnt", fwd_cnt[2], 16'd1);
`endif
        tick;

        // 3: MODE 1 write after accept is not reflected
        tick; wb(1, 1'b1, 5'd3, 32'h11);
        tick; wb(1, 1'b0, 5'd0, 32'h0); req(1, 1'b1, 5'd3, 5'd0);
        tick; req(1, 1'b0, 5'd0, 5'd0); wb(1, 1'b1, 5'd3, 32'h55);
        tick; wb(1, 1'b0, 5'd0, 32'h0);
        chk("t3_rsp_valid", rsp_valid[1], 1'b1);
        chk("t3_rd1", rsp_rd1[1], 32'h11);
        chk("t3_rd2", rsp_rd2[1], 32'h0);
        tick;

        // 4: writes to $zero are dropped and never forwarded
        tick; wb(0, 1'b1, 5'd0, 32'hFFFF); req(0, 1'b1, 5'd0, 5'd0); #1;
        chk("t4_wen", rf_wen[0], 1'b0);
        tick; wb(0, 1'b0, 5'd0, 32'h0); req(0, 1'b0, 5'd0, 5'd0);
        chk("t4_rsp_valid", rsp_valid[0], 1'b1);
        chk("t4_rd1", rsp_rd1[0], 32'h0);
        chk("t4_rd2", rsp_rd2[0], 32'h0);

        // 5: MODE 0 backpressure then same-cycle re-accept
        tick; wb(0, 1'b1, 5'd9, 32'h9999);
        tick; wb(0, 1'b1, 5'd10, 32'hA0A0);
        tick; wb(0, 1'b0, 5'd0, 32'h0); req(0, 1'b1, 5'd9, 5'd10); rsp_ready[0] = 1'b0;
        tick; req(0, 1'b1, 5'd10, 5'd9); wb(0, 1'b1, 5'd9, 32'h7777); #1;
        for (int i = 0; i < 4; i++) begin
            chk("t5_hold_valid", rsp_valid[0], 1'b1);
            chk("t5_hold_rd1", rsp_rd1[0], 32'h9999);
            chk("t5_hold_rd2", rsp_rd2[0], 32'hA0A0);
            chk("t5_hold_ready", req_ready[0], 1'b0);
            tick; wb(0, 1'b0, 5'd0, 32'h0);
        end
        rsp_ready[0] = 1'b1; #1;
        chk("t5_reaccept_ready", req_ready[0], 1'b1);
        chk("t5_reaccept_ra1", rf_ra1[0], 5'd10);
        tick; req(0, 1'b0, 5'd0, 5'd0);
        chk("t5_rsp_valid", rsp_valid[0], 1'b1);
        chk("t5_rd1", rsp_rd1[0], 32'hA0A0);
        chk("t5_rd2", rsp_rd2[0], 32'h7777);
        tick;

        // 6: MODE 2 reset while waiting for the file
        tick; req(2, 1'b1, 5'd7, 5'd0);
        tick; req(2, 1'b0, 5'd0, 5'd0);
        #2; rst[2] = 1'b1; wb(2, 1'b1, 5'd4, 32'h1); #1;
        chk("t6_rst_wen", rf_wen[2], 1'b0);
        chk("t6_rst_ready", req_ready[2], 1'b0);
        chk("t6_rst_valid", rsp_valid[2], 1'b0);
        tick; rst[2] = 1'b0; wb(2, 1'b0, 5'd0, 32'h0);
        tick;
        chk("t6_valid", rsp_valid[2], 1'b0);
        chk("t6_rd1", rsp_rd1[2], 32'h0);
        chk("t6_idle_ready", req_ready[2], 1'b1);
        tick;
        chk("t6_valid_later", rsp_valid[2], 1'b0);
`ifdef RF_ACC_STATS_EN
        chk("t6_fwd_cnt", fwd_cnt[2], 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
